cpu_control: RTL and testbench
==============================

# cpu_control

Multi-cycle instruction sequencer for the Hack-style 16-bit datapath. Fetches instructions over an instruction-memory handshake and decodes A- and C-instructions. Sequences the registered ALU: drives its opcode, x and y, then captures its result one cycle later. Owns the A, D and PC registers, performs data-memory reads and writes for M operands, and evaluates jumps.

## Interface
No parameters.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset; shared with the ALU
- imem_req  out  1  instruction fetch request
- imem_addr  out  15  fetch address (= pc)
- imem_valid  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  16  instruction word
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  15  data address (= A[14:0])
- dmem_wdata  out  16  write data
- dmem_valid  in  1  data access complete; dmem_rdata valid on reads
- dmem_rdata  in  16  read data
- alu_opcode  out  7  {1'b0, ir[11:6]}
- alu_x  out  16  D register
- alu_y  out  16  ir[12] ? M latch : A register
- alu_result  in  16  ALU registered output
- pc  out  15  program counter
- a_reg, d_reg  out  16  architectural A and D
- instr_done  out  1  one-cycle pulse when an instruction retires

## Operation
- Instruction formats:
  - ir[15]=0 is an A-instruction: A <= {1'b0, ir[14:0]}.
  - ir[15]=1 is a C-instruction: a=ir[12], comp=ir[11:6], dest=ir[5:3] (A, D, M), jump=ir[2:0] (lt, eq, gt).
- States and transitions:
  - FETCH: imem_req=1, imem_addr=pc. On imem_valid: latch ir, go to DECODE.
  - DECODE, A-instruction: load A, pc <= pc+1, instr_done=1, go to FETCH.
  - DECODE, C-instruction: go to MREAD if a=1, else to EXEC.
  - MREAD: dmem_req=1, dmem_we=0, dmem_addr=A[14:0]. On dmem_valid: latch M, go to EXEC.
  - EXEC: alu_opcode, alu_x and alu_y stable; the ALU samples them at the end of this cycle. Go to WB.
  - WB: alu_result is valid. Flags: zr = (alu_result==0), ng = alu_result[15]; this block computes both. Write D if dest[1]. Write A if dest[2]. Latch the result into dmem_wdata. Latch A_old (A before this write) as the write address and jump target.
  - WB, dest[0]=1: go to MWRITE.
  - WB, dest[0]=0: pc update, instr_done=1, go to FETCH.
  - MWRITE: dmem_req=1, dmem_we=1, dmem_addr=A_old[14:0]. On dmem_valid: pc update, instr_done=1, go to FETCH.
- Pc update:
  - take = (j1&ng) | (j2&zr) | (j3&~ng&~zr).
  - pc <= take ? A_old[14:0] : pc+1.
- Width rules:
  - pc is 15 bits and wraps from 0x7FFF to 0x0000.
  - A and D are 16 bits.
  - Memory addresses use A[14:0]; A[15] is ignored.
- Handshake rules:
  - req, addr, we and wdata are held stable until valid is sampled high in the same cycle.
  - valid may arrive in the same cycle as req (zero-wait memory).
  - valid while req is low is ignored.
  - req deasserts the cycle after completion, except FETCH→FETCH does not occur.

## Timing
- Reset:
  - State becomes FETCH.
  - pc, A, D, ir and the M latch become 0.
  - All req, we, instr_done and address outputs are 0 during the rst cycle.
  - imem_req rises in the first cycle after rst falls.
- Latency with zero-wait memory:
  - A-instruction: 2 cycles.
  - C-instruction: 4 cycles.
  - +1 cycle for an M read; +1 cycle for an M write.
  - Each memory wait state adds 1 cycle.
- instr_done is high exactly in the final cycle of each instruction; pc, A and D show new values the cycle after.
- A C-instruction with a=1 and dest including M reads and writes the same address A_old.
- rst asserted in any state, including mid-MREAD or mid-MWRITE:
  - Outstanding request dropped the next cycle; no retry.
  - No architectural update from the aborted instruction.
  - The memory side must tolerate an abandoned request.

## Test plan
- Reset: hold rst 2 cycles → all outputs 0. First cycle after release: imem_req=1, imem_addr=0.
- Program 0x0005, 0xEC10 (@5; D=A), zero-wait → A=5, D=5, pc=2; instr_done pulses at cycle 2 and cycle 6 after reset.
- Program 0x0064, 0xFDC8 (@100; M=M+1) with mem[100]=41 → read at addr 100, then write addr 100 with data 42. The second instruction takes 6 cycles; dmem_we is high only in MWRITE.
- Jumps:
  - Program D=0 via 0xEA90, then 0x0007, then 0xE302 (D;JEQ) → pc=7.
  - Repeat with D=1 → pc=3.
  - 0xEA87 (0;JMP) with A=0x1234 → pc=0x1234.
- imem_valid delayed 3 cycles → imem_addr stable throughout, a single fetch per instruction, and instruction latency +3.
- Boundary cases:
  - A-instruction fetched at pc=0x7FFF → pc=0x0000.
  - rst asserted in MWRITE with dmem_valid low → dmem_req=0 the next cycle; pc, A and D are 0, and no write completes.

Source files
------------

// File: rtl/cpu_control.sv
// cpu_control: multi-cycle sequencer for a Hack-style 16-bit datapath.
// It fetches over an instruction-memory handshake and decodes A- and
// C-instructions. It drives an external registered ALU and reads/writes
// data memory for M operands. It owns the A, D and PC registers and
// evaluates jumps.
module cpu_control (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [14:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [14:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_valid,
  input  logic [15:0] dmem_rdata,
  output logic [6:0]  alu_opcode,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  input  logic [15:0] alu_result,
  output logic [14:0] pc,
  output logic [15:0] a_reg,
  output logic [15:0] d_reg,
  output logic        instr_done
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MREAD,
    S_EXEC,
    S_WB,
    S_MWRITE
  } state_t;

  state_t      r_state;
  logic [15:0] r_ir;
  logic [15:0] r_a;
  logic [15:0] r_d;
  logic [15:0] r_m;       // M operand captured by MREAD
  logic [15:0] r_a_old;   // A before the WB write: M-write address and jump target
  logic [15:0] r_wdata;   // ALU result held for the M write
  logic [14:0] r_pc;
  logic        r_take;    // jump decision carried from WB into MWRITE

  // Instruction fields and jump evaluation on the ALU result visible in WB
  logic [2:0]  w_dest;
  logic [2:0]  w_jump;
  logic        w_zr;
  logic        w_ng;
  logic        w_take;
  logic [14:0] w_pc_inc;

  assign w_dest   = r_ir[5:3];
  assign w_jump   = r_ir[2:0];
  assign w_zr     = (alu_result == 16'h0000);
  assign w_ng     = alu_result[15];
  assign w_take   = (w_jump[2] & w_ng) | (w_jump[1] & w_zr) | (w_jump[0] & ~w_ng & ~w_zr);
  assign w_pc_inc = r_pc + 15'd1;   // 15-bit sum wraps 0x7FFF -> 0x0000

  // ALU operands come straight from the architectural state and the latched IR
  assign alu_opcode = {1'b0, r_ir[11:6]};
  assign alu_x      = r_d;
  assign alu_y      = r_ir[12] ? r_m : r_a;
  assign dmem_wdata = r_wdata;
  assign pc         = r_pc;
  assign a_reg      = r_a;
  assign d_reg      = r_d;

  // Sequencer: state transitions plus every architectural register update
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the values from the start of the cycle, e.g. r_a_old captures A before
  // the same-cycle write of A in WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ir    <= 16'h0000;
      r_a     <= 16'h0000;
      r_d     <= 16'h0000;
      r_m     <= 16'h0000;
      r_a_old <= 16'h0000;
      r_wdata <= 16'h0000;
      r_pc    <= 15'h0000;
      r_take  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_valid) begin
            r_ir    <= imem_data;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!r_ir[15]) begin
            r_a     <= {1'b0, r_ir[14:0]};
            r_pc    <= w_pc_inc;
            r_state <= S_FETCH;
          end else begin
            r_state <= r_ir[12] ? S_MREAD : S_EXEC;
          end
        end
        S_MREAD: begin
          if (dmem_valid) begin
            r_m     <= dmem_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= S_WB;
        end
        S_WB: begin
          if (w_dest[1]) r_d <= alu_result;
          if (w_dest[2]) r_a <= alu_result;
          r_wdata <= alu_result;
          r_a_old <= r_a;
          r_take  <= w_take;
          if (w_dest[0]) begin
            r_state <= S_MWRITE;
          end else begin
            r_pc    <= w_take ? r_a[14:0] : w_pc_inc;
            r_state <= S_FETCH;
          end
        end
        S_MWRITE: begin
          if (dmem_valid) begin
            r_pc    <= r_take ? r_a_old[14:0] : w_pc_inc;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Handshake outputs decoded from the state register. They are forced low
  // while rst is high, so a request is abandoned at once and nothing shows
  // during reset. Zero-wait memory needs req in the same cycle as the state.
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = 15'h0000;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 15'h0000;
    instr_done = 1'b0;
    if (!rst) begin
      imem_addr = r_pc;
      case (r_state)
        S_FETCH:  imem_req = 1'b1;
        S_DECODE: instr_done = ~r_ir[15];
        S_MREAD: begin
          dmem_req  = 1'b1;
          dmem_addr = r_a[14:0];
        end
        S_WB:     instr_done = ~w_dest[0];
        S_MWRITE: begin
          dmem_req   = 1'b1;
          dmem_we    = 1'b1;
          dmem_addr  = r_a_old[14:0];
          instr_done = dmem_valid;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// tb_cpu_control: scoreboard bench for cpu_control. Each completed fetch runs
// an instruction-level Hack interpreter. It queues the expected pc/A/D,
// latency and memory traffic. Independent responder and monitor processes
// compare the DUT against those queues.
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic        dmem_req;
  logic        dmem_we;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_valid = 1'b0;
  logic [15:0] dmem_rdata = 16'h0000;
  logic [6:0]  alu_opcode;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [15:0] alu_result = 16'h0000;
  logic [14:0] pc;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic        instr_done;

  cpu_control dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_valid (dmem_valid),
    .dmem_rdata (dmem_rdata),
    .alu_opcode (alu_opcode),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_result (alu_result),
    .pc         (pc),
    .a_reg      (a_reg),
    .d_reg      (d_reg),
    .instr_done (instr_done)
  );

  // Posedges at 5, 15, ...; negedges at 10, 20, ...
  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string detail);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, detail, $time);
  endtask

  // Memories: imem/dmem are the environment, ref_mem is the model's view
  logic [15:0] imem    [32768];
  logic [15:0] dmem    [32768];
  logic [15:0] ref_mem [32768];

  // Hack ALU: zx nx zy ny f no
  function automatic logic [15:0] hack_alu(input logic [5:0] c, input logic [15:0] x,
                                           input logic [15:0] y);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  // Registered ALU: operands sampled mid-cycle, result presented the next cycle
  initial begin : alu_model
    logic [15:0] held;
    held = 16'h0000;
    forever begin
      @(negedge clk);
      #1;
      held = hack_alu(alu_opcode[5:0], alu_x, alu_y);
      @(posedge clk);
      #1;
      alu_result = held;
    end
  end

  // Scoreboard items
  typedef struct {
    logic [14:0] pc;
    logic [15:0] a;
    logic [15:0] d;
    int          lat;
  } exp_t;
  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  exp_t        exp_q[$];
  logic [14:0] rd_q[$];
  wr_t         wr_q[$];

  // Reference architectural state
  logic [14:0] m_pc = 15'h0000;
  logic [15:0] m_a  = 16'h0000;
  logic [15:0] m_d  = 16'h0000;
  bit          undo_pending = 1'b0;
  logic [14:0] undo_addr = 15'h0000;
  logic [15:0] undo_val  = 16'h0000;

  // Wait-state configuration
  bit random_mode = 1'b0;
  int im_wait_cfg = 0;
  int rd_wait_cfg = 0;
  int wr_wait_cfg = 0;
  int cur_rd_wait = 0;
  int cur_wr_wait = 0;
  int fetch_count = 0;

  // One Hack instruction executed at ISA level; wi = fetch wait states
  task automatic model_step(input logic [15:0] ins, input int wi);
    exp_t        e;
    wr_t         w;
    logic [15:0] y, res, old_a;
    logic        take;
    if (random_mode) begin
      cur_rd_wait = int'($urandom_range(0, 2));
      cur_wr_wait = int'($urandom_range(0, 2));
    end else begin
      cur_rd_wait = rd_wait_cfg;
      cur_wr_wait = wr_wait_cfg;
    end
    if (!ins[15]) begin
      m_a   = {1'b0, ins[14:0]};
      m_pc  = m_pc + 15'd1;
      e.lat = wi + 2;
    end else begin
      e.lat = wi + 4;
      y = m_a;
      if (ins[12]) begin
        y = ref_mem[m_a[14:0]];
        rd_q.push_back(m_a[14:0]);
        e.lat += cur_rd_wait + 1;
      end
      res   = hack_alu(ins[11:6], m_d, y);
      old_a = m_a;
      if (ins[3]) begin
        w.addr = old_a[14:0];
        w.data = res;
        wr_q.push_back(w);
        undo_pending = 1'b1;
        undo_addr    = old_a[14:0];
        undo_val     = ref_mem[old_a[14:0]];
        ref_mem[old_a[14:0]] = res;
        e.lat += cur_wr_wait + 1;
      end
      if (ins[4]) m_d = res;
      if (ins[5]) m_a = res;
      take = (ins[2] && ($signed(res) < 0)) || (ins[1] && (res == 16'h0000)) ||
             (ins[0] && ($signed(res) > 0));
      m_pc = take ? old_a[14:0] : (m_pc + 15'd1);
    end
    e.pc = m_pc;
    e.a  = m_a;
    e.d  = m_d;
    exp_q.push_back(e);
  endtask

  // Instruction memory responder (acts at negedge+1)
  initial begin : imem_resp
    int          wait_left;
    int          wi;
    bit          busy;
    logic [14:0] addr0;
    wait_left = 0;
    wi        = 0;
    busy      = 1'b0;
    addr0     = 15'h0000;
    forever begin
      @(negedge clk);
      #1;
      if (imem_req) begin
        if (!busy) begin
          busy      = 1'b1;
          addr0     = imem_addr;
          wait_left = random_mode ? int'($urandom_range(0, 3)) : im_wait_cfg;
          wi        = wait_left;
        end else begin
          check("imem_addr_stable", 32'(imem_addr), 32'(addr0));
        end
        if (wait_left == 0) begin
          imem_valid = 1'b1;
          imem_data  = imem[imem_addr];
          fetch_count++;
          check("fetch_addr", 32'(imem_addr), 32'(m_pc));
          model_step(imem[imem_addr], wi);
        end else begin
          imem_valid = 1'b0;
          imem_data  = 16'($urandom);
          wait_left--;
        end
      end else begin
        busy       = 1'b0;
        imem_valid = 1'($urandom_range(0, 1));
        imem_data  = 16'($urandom);
      end
    end
  end

  // Data memory responder (acts at negedge+1)
  initial begin : dmem_resp
    int          wait_left;
    bit          busy;
    logic [14:0] addr0;
    logic [15:0] data0;
    logic        we0;
    wr_t         w;
    wait_left = 0;
    busy      = 1'b0;
    addr0     = 15'h0000;
    data0     = 16'h0000;
    we0       = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (dmem_req) begin
        if (!busy) begin
          busy      = 1'b1;
          addr0     = dmem_addr;
          we0       = dmem_we;
          data0     = dmem_wdata;
          wait_left = dmem_we ? cur_wr_wait : cur_rd_wait;
          if (dmem_we) begin
            if (wr_q.size() == 0) begin
              fail_now("unexpected_write", $sformatf("write to 0x%0h, none expected", dmem_addr));
            end else begin
              w = wr_q.pop_front();
              check("write_addr", 32'(dmem_addr), 32'(w.addr));
              check("write_data", 32'(dmem_wdata), 32'(w.data));
            end
          end else begin
            if (rd_q.size() == 0)
              fail_now("unexpected_read", $sformatf("read of 0x%0h, none expected", dmem_addr));
            else
              check("read_addr", 32'(dmem_addr), 32'(rd_q.pop_front()));
          end
        end else begin
          check("dmem_addr_stable", 32'(dmem_addr), 32'(addr0));
          check("dmem_we_stable", 32'(dmem_we), 32'(we0));
          if (we0) check("dmem_wdata_stable", 32'(dmem_wdata), 32'(data0));
        end
        if (wait_left == 0) begin
          dmem_valid = 1'b1;
          if (we0) begin
            dmem[dmem_addr] = dmem_wdata;
            undo_pending    = 1'b0;
          end else begin
            dmem_rdata = dmem[dmem_addr];
          end
        end else begin
          dmem_valid = 1'b0;
          dmem_rdata = 16'($urandom);
          wait_left--;
        end
      end else begin
        busy       = 1'b0;
        dmem_valid = 1'($urandom_range(0, 1));
        dmem_rdata = 16'($urandom);
      end
    end
  end

  // Retirement monitor (acts at negedge+2)
  initial begin : monitor
    exp_t e;
    bit   pending;
    int   last_done;
    pending   = 1'b0;
    last_done = 0;
    forever begin
      @(negedge clk);
      #2;
      if (pending) begin
        check("pc", 32'(pc), 32'(e.pc));
        check("a_reg", 32'(a_reg), 32'(e.a));
        check("d_reg", 32'(d_reg), 32'(e.d));
        pending = 1'b0;
      end
      if (dmem_we) check("we_needs_req", 32'(dmem_req), 32'd1);
      if (rst) begin
        last_done = cyc;
      end else if (instr_done) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_done", "instr_done high with no instruction outstanding");
        end else begin
          e = exp_q.pop_front();
          check("latency", 32'(cyc - last_done), 32'(e.lat));
          pending = 1'b1;
        end
        last_done = cyc;
      end
    end
  end

  // Drop all in-flight expectations and return the model to its reset state
  task automatic flush_model();
    exp_q.delete();
    rd_q.delete();
    wr_q.delete();
    if (undo_pending) begin
      ref_mem[undo_addr] = undo_val;
      undo_pending = 1'b0;
    end
    m_pc = 15'h0000;
    m_a  = 16'h0000;
    m_d  = 16'h0000;
    fetch_count = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    flush_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait for n retirements, then one more cycle so new pc/A/D are visible
  task automatic run_instrs(input int n);
    int got;
    int budget;
    got    = 0;
    budget = 0;
    while (got < n && budget < 200 * n) begin
      @(negedge clk);
      #3;
      budget++;
      if (instr_done) got++;
    end
    if (got < n) fail_now("timeout", $sformatf("got %0d instr_done pulses, need %0d", got, n));
    @(negedge clk);
    #3;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 8; i++) imem[i] = 16'h0000;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int budget;
    for (int i = 0; i < 32768; i++) begin
      imem[i]    = 16'h0000;
      dmem[i]    = 16'h0000;
      ref_mem[i] = 16'h0000;
    end

    // Reset held for two cycles; everything quiet, then fetch from 0
    imem[0] = 16'h0005;
    imem[1] = 16'hEC10;             // D=A
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_instr_done", 32'(instr_done), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_dmem_addr", 32'(dmem_addr), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_a", 32'(a_reg), 32'd0);
    check("rst_d", 32'(d_reg), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #3;
    check("post_rst_imem_req", 32'(imem_req), 32'd1);
    check("post_rst_imem_addr", 32'(imem_addr), 32'd0);
    run_instrs(2);
    check("p1_a", 32'(a_reg), 32'h5);
    check("p1_d", 32'(d_reg), 32'h5);
    check("p1_pc", 32'(pc), 32'h2);

    // M=M+1 at address 100
    clear_prog();
    imem[0] = 16'h0064;
    imem[1] = 16'hFDC8;
    dmem[100]    = 16'd41;
    ref_mem[100] = 16'd41;
    do_reset();
    run_instrs(2);
    check("p2_mem100", 32'(dmem[100]), 32'd42);
    check("p2_a", 32'(a_reg), 32'd100);

    // D=0; @7; D;JEQ -> taken
    clear_prog();
    imem[0] = 16'hEA90;
    imem[1] = 16'h0007;
    imem[2] = 16'hE302;
    do_reset();
    run_instrs(3);
    check("jeq_taken_pc", 32'(pc), 32'd7);

    // D=1; @7; D;JEQ -> not taken
    imem[0] = 16'hEFD0;
    do_reset();
    run_instrs(3);
    check("jeq_not_taken_pc", 32'(pc), 32'd3);

    // @0x1234; 0;JMP
    clear_prog();
    imem[0] = 16'h1234;
    imem[1] = 16'hEA87;
    do_reset();
    run_instrs(2);
    check("jmp_pc", 32'(pc), 32'h1234);

    // Fetch of an A-instruction at 0x7FFF wraps pc to 0
    imem[0]      = 16'h7FFF;
    imem[1]      = 16'hEA87;
    imem[16'h7FFF] = 16'h0003;
    do_reset();
    run_instrs(3);
    check("wrap_pc", 32'(pc), 32'd0);
    check("wrap_a", 32'(a_reg), 32'd3);

    // Three fetch wait states on each instruction
    clear_prog();
    imem[0] = 16'h0005;
    imem[1] = 16'hEC10;
    im_wait_cfg = 3;
    do_reset();
    run_instrs(2);
    check("slow_fetch_count", 32'(fetch_count), 32'd2);
    check("slow_d", 32'(d_reg), 32'd5);
    im_wait_cfg = 0;

    // Random programs with random wait states
    for (int i = 0; i < 32768; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(0, 9) < 4) r[15] = 1'b0;
      else r[15:13] = 3'b111;
      imem[i]    = r;
      dmem[i]    = 16'($urandom);
      ref_mem[i] = dmem[i];
    end
    random_mode = 1'b1;
    do_reset();
    run_instrs(300);
    random_mode = 1'b0;

    // Reset while an M write is stalled: request dropped, nothing committed
    clear_prog();
    imem[0] = 16'h0064;
    imem[1] = 16'hFDC8;
    dmem[100]    = 16'd41;
    ref_mem[100] = 16'd41;
    wr_wait_cfg  = 50;
    do_reset();
    budget = 0;
    while (!(dmem_req && dmem_we) && budget < 40) begin
      @(negedge clk);
      #3;
      budget++;
    end
    if (!(dmem_req && dmem_we))
      fail_now("abort_reach_mwrite", $sformatf("no write request within %0d cycles", budget));
    @(negedge clk);
    rst = 1'b1;
    flush_model();
    #3;
    check("abort_req_dropped", 32'(dmem_req), 32'd0);
    @(negedge clk);
    #3;
    check("abort_req_next", 32'(dmem_req), 32'd0);
    check("abort_pc", 32'(pc), 32'd0);
    check("abort_a", 32'(a_reg), 32'd0);
    check("abort_d", 32'(d_reg), 32'd0);
    check("abort_mem100", 32'(dmem[100]), 32'd41);
    wr_wait_cfg = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
